// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [2:0] {IDLE, PROBE, LOAD, DONE, ERR} loader_state_e;

  // bit_cnt must hold 2*BS_LGT (probe timeout) without wrapping
  function automatic int ccff_cnt_w(input int bs_lgt);
    return $clog2(2 * bs_lgt + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Two-entry word buffer (shift register + holding register) that feeds one
// bit per shift; HR refills SR on the same edge SR runs dry.
module ccff_word_serializer #(
  parameter int WORD_W = 32
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              shift,
  output logic              hr_empty,
  output logic              bit_o,
  output logic              sr_vld
);

  localparam int CW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] sr_q, sr_d, hr_q, hr_d;
  logic [CW-1:0]     sr_cnt_q, sr_cnt_d;
  logic              hr_full_q, hr_full_d;

  always_comb begin
    sr_d      = sr_q;
    sr_cnt_d  = sr_cnt_q;
    hr_d      = hr_q;
    hr_full_d = hr_full_q;
    if (shift) begin
      sr_d     = sr_q >> 1;
      sr_cnt_d = sr_cnt_q - CW'(1);
    end
    if (sr_cnt_d == '0 && hr_full_q) begin
      sr_d      = hr_q;
      sr_cnt_d  = CW'(WORD_W);
      hr_full_d = 1'b0;
    end
    // new word goes straight to SR when it would otherwise sit idle
    if (in_valid) begin
      if (sr_cnt_d == '0) begin
        sr_d     = in_data;
        sr_cnt_d = CW'(WORD_W);
      end else begin
        hr_d      = in_data;
        hr_full_d = 1'b1;
      end
    end
    if (flush) begin
      sr_cnt_d  = '0;
      hr_full_d = 1'b0;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      sr_q      <= '0;
      hr_q      <= '0;
      sr_cnt_q  <= '0;
      hr_full_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      hr_q      <= hr_d;
      sr_cnt_q  <= sr_cnt_d;
      hr_full_q <= hr_full_d;
    end
  end

  assign hr_empty = ~hr_full_q;
  assign bit_o    = sr_q[0];
  assign sr_vld   = (sr_cnt_q != '0);

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain driver: probes chain length with a single-'1' token,
// then streams the word-fed bitstream into ccff_head with a gated shift enable.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int BS_LGT   = 8387,
  parameter int WORD_W   = 32,
  parameter int PROBE_EN = 1,
  localparam int CNT_W   = ccff_cnt_w(BS_LGT)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              config_done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam int N_WORDS = (BS_LGT + WORD_W - 1) / WORD_W;
  localparam int WC_W    = $clog2(N_WORDS + 1);

  loader_state_e    state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]  wrd_cnt_q, wrd_cnt_d;
  logic             ld, accept, hr_empty, ser_bit, sr_vld;

  assign ld      = (state_q == LOAD);
  // stop accepting once the words covering BS_LGT bits are in
  assign s_ready = ld & hr_empty & (wrd_cnt_q != WC_W'(N_WORDS));
  assign accept  = s_valid & s_ready;

  ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .flush    (~ld),
    .in_valid (accept),
    .in_data  (s_data),
    .shift    (ld & sr_vld),
    .hr_empty (hr_empty),
    .bit_o    (ser_bit),
    .sr_vld   (sr_vld)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    wrd_cnt_d = accept ? wrd_cnt_q + WC_W'(1) : wrd_cnt_q;
    shift_en  = 1'b0;
    ccff_head = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d   = (PROBE_EN != 0) ? PROBE : LOAD;
          bit_cnt_d = '0;
          wrd_cnt_d = '0;
        end
      end
      PROBE: begin
        shift_en  = 1'b1;
        ccff_head = (bit_cnt_q == '0);
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        // tail reflects the chain after bit_cnt_q shifts
        if (ccff_tail) begin
          if (bit_cnt_q == CNT_W'(BS_LGT)) begin
            state_d   = LOAD;
            bit_cnt_d = '0;
          end else begin
            state_d = ERR;
          end
        end else if (bit_cnt_q == CNT_W'(2 * BS_LGT - 1)) begin
          state_d = ERR;
        end
      end
      LOAD: begin
        shift_en  = sr_vld;
        ccff_head = sr_vld & ser_bit;
        if (sr_vld) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(BS_LGT - 1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      wrd_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      wrd_cnt_q <= wrd_cnt_d;
    end
  end

  assign busy        = (state_q == PROBE) | ld;
  assign config_done = (state_q == DONE);
  assign error       = (state_q == ERR);
  assign bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench: behavioural chain model plus a bit scoreboard that is
// filled on word acceptance and drained on every LOAD shift.
module tb_ccff_bitstream_loader;

  localparam int BS = 10;
  localparam int W  = 4;

  logic         prog_clk = 1'b0;
  logic         pReset   = 1'b1;
  logic         start    = 1'b0;
  logic [W-1:0] s_data   = '0;
  logic         s_valid  = 1'b0;
  logic         s_ready, ccff_head, shift_en, ccff_tail, busy, config_done, error;
  logic [4:0]   bit_cnt;

  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader #(.BS_LGT(BS), .WORD_W(W), .PROBE_EN(1)) dut (
    .prog_clk    (prog_clk),
    .pReset      (pReset),
    .start       (start),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .ccff_head   (ccff_head),
    .shift_en    (shift_en),
    .ccff_tail   (ccff_tail),
    .busy        (busy),
    .config_done (config_done),
    .error       (error),
    .bit_cnt     (bit_cnt)
  );

  // chain model: head enters chain[0], tail is chain[chain_len-1]
  logic [9:0] chain;
  logic       chain_clr = 1'b1;
  logic [3:0] chain_len = 4'd10;
  logic       tail_tie0 = 1'b0;

  always @(posedge prog_clk)
    if (chain_clr) chain <= '0;
    else if (shift_en) chain <= {chain[8:0], ccff_head};

  assign ccff_tail = tail_tie0 ? 1'b0 : chain[chain_len - 4'd1];

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard and phase statistics
  bit         exp_q[$];
  bit         ld_on = 1'b0;
  int         ld_cycles = 0, ld_shifts = 0, pr_shifts = 0, arr_cnt = -1, done_rises = 0;
  logic       done_prev = 1'b0;
  logic [4:0] cnt_prev = '0;

  always @(negedge prog_clk) begin
    if (s_ready) ld_on = 1'b1;
    if (busy && ld_on) begin
      ld_cycles++;
      if (shift_en) begin
        ld_shifts++;
        if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("sb_bit", 32'(ccff_head), 32'(exp_q.pop_front()));
      end
      if (bit_cnt < cnt_prev) chk("bit_cnt_monotonic", 32'(bit_cnt), 32'(cnt_prev));
      cnt_prev = bit_cnt;
    end else if (busy) begin
      if (shift_en) pr_shifts++;
      if (ccff_tail && arr_cnt < 0) arr_cnt = int'(bit_cnt);
    end
    if (config_done && !done_prev) done_rises++;
    done_prev = config_done;
  end

  task automatic begin_test(input logic [3:0] len, input logic tie0);
    @(posedge prog_clk); #1;
    chain_len = len; tail_tie0 = tie0; chain_clr = 1'b1;
    exp_q.delete();
    ld_on = 1'b0; ld_cycles = 0; ld_shifts = 0; pr_shifts = 0;
    arr_cnt = -1; done_rises = 0; cnt_prev = '0;
    @(posedge prog_clk); #1;
    chain_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    bit got = 1'b0;
    s_data = w; s_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge prog_clk);
      if (s_ready) begin
        got = 1'b1;
        for (int b = 0; b < W; b++) exp_q.push_back(w[b]);
        break;
      end
    end
    if (!got) chk("send_timeout", 32'd0, 32'd1);
    @(posedge prog_clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_end();
    bit hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge prog_clk);
      if (config_done || error) begin hit = 1'b1; break; end
    end
    if (!hit) chk("end_timeout", 32'd0, 32'd1);
  endtask

  // shift order 0101_1010_11 leaves bit0 of word A at the tail end
  localparam logic [9:0] EXP_CHAIN = 10'b0101101011;

  task automatic check_done(input string tag, input int exp_ld_cycles);
    chk({tag, "_done"}, 32'(config_done), 32'd1);
    chk({tag, "_err"}, 32'(error), 32'd0);
    chk({tag, "_idle_outs"}, {busy, shift_en, ccff_head, s_ready}, 32'd0);
    chk({tag, "_bit_cnt"}, 32'(bit_cnt), 32'd10);
    chk({tag, "_ld_shifts"}, 32'(ld_shifts), 32'd10);
    chk({tag, "_chain"}, 32'(chain), 32'(EXP_CHAIN));
    chk({tag, "_dropped"}, 32'(exp_q.size()), 32'd2);
    if (exp_ld_cycles > 0) chk({tag, "_ld_cycles"}, 32'(ld_cycles), 32'(exp_ld_cycles));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge prog_clk);
    #1 pReset = 1'b0;
    @(negedge prog_clk);
    chk("rst_outs", {s_ready, ccff_head, shift_en, busy, config_done, error}, 32'd0);
    chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);

    // T1: nominal probe + load
    begin_test(4'd10, 1'b0);
    pulse_start();
    send_word(4'hA); send_word(4'h5); send_word(4'h3);
    wait_end();
    chk("t1_arrival", 32'(arr_cnt), 32'd10);
    check_done("t1", BS + 1);

    // T2: short chain, token early
    begin_test(4'd9, 1'b0);
    pulse_start();
    wait_end();
    chk("t2_error", 32'(error), 32'd1);
    chk("t2_done", 32'(config_done), 32'd0);
    chk("t2_arrival", 32'(arr_cnt), 32'd9);
    chk("t2_ready_never", 32'(ld_on), 32'd0);

    // T3: broken chain, probe timeout
    begin_test(4'd10, 1'b1);
    pulse_start();
    wait_end();
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_bit_cnt", 32'(bit_cnt), 32'd20);
    chk("t3_shifts", 32'(pr_shifts), 32'd20);
    repeat (3) @(negedge prog_clk);
    chk("t3_shift_off", {shift_en, busy, error}, 32'b001);

    // T4: source gap drains SR -> five bubble cycles
    begin_test(4'd10, 1'b0);
    pulse_start();
    send_word(4'hA);
    repeat (8) @(posedge prog_clk);
    #1;
    send_word(4'h5); send_word(4'h3);
    wait_end();
    check_done("t4", BS + 1 + 5);

    // T5: reset mid-load, then clean reload
    begin_test(4'd10, 1'b0);
    pulse_start();
    send_word(4'hA); send_word(4'h5);
    for (int i = 0; i < 50; i++) begin
      @(negedge prog_clk);
      if (ld_on && bit_cnt == 5'd6) break;
    end
    chk("t5_reached6", 32'(bit_cnt), 32'd6);
    pReset = 1'b1;
    @(posedge prog_clk); #1;
    pReset = 1'b0;
    @(negedge prog_clk);
    chk("t5_rst_outs", {s_ready, ccff_head, shift_en, busy, config_done, error}, 32'd0);
    chk("t5_rst_cnt", 32'(bit_cnt), 32'd0);
    begin_test(4'd10, 1'b0);
    pulse_start();
    send_word(4'hA); send_word(4'h5); send_word(4'h3);
    wait_end();
    check_done("t5", BS + 1);

    // T6: start while loading is ignored
    begin_test(4'd10, 1'b0);
    pulse_start();
    send_word(4'hA);
    pulse_start();
    send_word(4'h5); send_word(4'h3);
    wait_end();
    repeat (5) @(negedge prog_clk);
    check_done("t6", 0);
    chk("t6_done_rises", 32'(done_rises), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
